icetap_readout: RTL and testbench
=================================

Name: icetap_readout

Overview:
- Dump engine on the scan side of the capture RAM. It sits directly downstream of the capture block, on the capture block's RAM read port.
- On request, it reads the captured window in chronological order, from start_addr through stop_addr with wrap-around.
- It serializes each sample into bytes and frames them into a valid/ready byte stream, which feeds the host link (UART/JTAG TX).

Parameters:
- NR_SIGNALS, 16, width of one captured sample.
- RECORD_DEPTH, 256, RAM depth in samples; power of two, 2..65536.
- Derived, not overridable: ADDR_BITS = $clog2(RECORD_DEPTH); WORD_BYTES = (NR_SIGNALS+7)/8.

Ports:
- scan_clk  in  1  sole clock.
- scan_reset  in  1  synchronous, active-high reset.
- dump_req  in  1  single-cycle pulse; starts a dump when idle.
- start_addr  in  ADDR_BITS  oldest captured sample address; sampled on the accepted dump_req.
- stop_addr  in  ADDR_BITS  newest captured sample address, inclusive; sampled on the accepted dump_req.
- rd_ena  out  1  RAM read enable.
- rd_addr  out  ADDR_BITS  RAM read address.
- rd_data  in  NR_SIGNALS  RAM data, valid exactly 1 cycle after rd_ena.
- tx_valid  out  1  byte available.
- tx_data  out  8  byte value.
- tx_ready  in  1  sink accepts the byte; a transfer occurs when tx_valid && tx_ready.
- busy  out  1  high from the cycle after the accepted dump_req until the cycle after the last byte transfer.

Behaviour:
- Reset values: busy=0, tx_valid=0, tx_data=0, rd_ena=0, rd_addr=0, FSM=IDLE.
- Reset mid-dump aborts immediately; no partial frame resumes.
- Word count: N = ((stop_addr - start_addr) mod RECORD_DEPTH) + 1, computed ADDR_BITS+1 wide.
  - start==stop gives N=1; stop==start-1 gives N=RECORD_DEPTH.
- Frame byte order:
  - 0xA5.
  - N[7:0], then N[15:8], zero-extended.
  - N samples, each as WORD_BYTES bytes little-endian; unused upper bits are zero.
  - 0x5A.
- FSM states: IDLE, HDR, FETCH, WAIT, SEND, TRL.
  - IDLE: on dump_req, latch start_addr/stop_addr, compute N, clear byte/word counters, go to HDR. dump_req is ignored in every other state.
  - HDR: present the 3 header bytes in order; after the third transfer go to FETCH.
  - FETCH: assert rd_ena for one cycle with rd_addr = (start + word_idx) mod RECORD_DEPTH (natural ADDR_BITS wrap); go to WAIT.
  - WAIT: capture rd_data into the word register (zero-padded to 8*WORD_BYTES); go to SEND.
  - SEND: present word bytes LSB first. After the last byte's transfer: if word_idx==N-1, go to TRL; otherwise word_idx+=1 and go to FETCH.
  - TRL: present 0x5A; on its transfer go to IDLE and drop busy.
- Handshake rules:
  - Once tx_valid rises, tx_valid and tx_data stay stable until the transfer.
  - tx_valid never drops without a transfer, except on reset.
  - No combinational path from tx_ready to tx_valid.
- Throughput: with tx_ready tied high, one sample costs 2 + WORD_BYTES cycles.
- rd_ena is asserted only in FETCH; rd_addr holds its value otherwise.
- The sampled start/stop are used for the whole dump; later input changes have no effect.

Optional Feature:
- Macro: ICETAP_READOUT_CRC_EN.
- Defined:
  - A CRC-8 (poly 0x07, init 0x00, MSB-first, no reflection, no final XOR) runs over every transferred byte from 0xA5 through the last sample byte.
  - An extra state CRC, between the last sample byte and TRL, emits the CRC byte.
  - Frame length grows by 1.
- Undefined: no CRC logic and no CRC byte; frame exactly as above.

Test Plan:
- Basic dump, depth 256, width 16: start=0x10, stop=0x13, RAM[a]={a,~a}, tx_ready=1 -> bytes A5 04 00 EF 10 EE 11 ED 12 EC 13 5A; busy high for exactly 3+4*4+1 transfer cycles.
- Wrap-around: start=0xFE, stop=0x01 -> N=4; rd_addr sequence FE,FF,00,01; header A5 04 00.
- Full buffer: start=0x40, stop=0x3F -> N=256, header A5 00 01; 256 samples, last one read from 0x3F.
- Backpressure: tx_ready toggles pseudo-randomly -> every byte appears exactly once, in order; tx_data never changes while tx_valid && !tx_ready.
- Ignore and abort:
  - dump_req pulsed mid-dump -> frame unchanged.
  - scan_reset asserted during SEND -> next cycle tx_valid=0, busy=0, rd_ena=0.
  - A fresh dump_req afterwards -> complete frame beginning A5.
- NR_SIGNALS=12, start=stop=0x05, RAM=0xABC -> A5 01 00 BC 0A 5A. With ICETAP_READOUT_CRC_EN, the CRC byte is inserted before 5A and matches the reference CRC-8 of A5 01 00 BC 0A.

Source files
------------

// File: rtl/icetap_readout_if.sv
// Bus bundle for icetap_readout: dump request, capture-RAM read port and TX byte stream.
// The master modport is the readout engine's view; slave is the surrounding logic's view.
interface icetap_readout_if #(
  parameter int unsigned NR_SIGNALS   = 16,
  parameter int unsigned RECORD_DEPTH = 256
) ();
  localparam int unsigned ADDR_BITS = $clog2(RECORD_DEPTH);

  logic                  dump_req;
  logic [ADDR_BITS-1:0]  start_addr;
  logic [ADDR_BITS-1:0]  stop_addr;
  logic                  rd_ena;
  logic [ADDR_BITS-1:0]  rd_addr;
  logic [NR_SIGNALS-1:0] rd_data;
  logic                  tx_valid;
  logic [7:0]            tx_data;
  logic                  tx_ready;
  logic                  busy;

  modport master (
    input  dump_req, start_addr, stop_addr, rd_data, tx_ready,
    output rd_ena, rd_addr, tx_valid, tx_data, busy
  );

  modport slave (
    output dump_req, start_addr, stop_addr, rd_data, tx_ready,
    input  rd_ena, rd_addr, tx_valid, tx_data, busy
  );
endinterface

// File: rtl/icetap_readout.sv
// Capture-RAM dump engine: reads start..stop (wrapping) and frames samples as a byte stream.
// Optional CRC-8 byte before the trailer when ICETAP_READOUT_CRC_EN is defined.
module icetap_readout #(
  parameter int unsigned NR_SIGNALS   = 16,
  parameter int unsigned RECORD_DEPTH = 256
) (
  input  logic             scan_clk,
  input  logic             scan_reset,
  icetap_readout_if.master bus
);
  localparam int unsigned ADDR_BITS  = $clog2(RECORD_DEPTH);
  localparam int unsigned WORD_BYTES = (NR_SIGNALS + 7) / 8;
  localparam int unsigned WORD_W     = 8 * WORD_BYTES;
  localparam int unsigned CNT_W      = ADDR_BITS + 1;
  localparam logic [7:0]  LastByte   = 8'(WORD_BYTES - 1);

`ifdef ICETAP_READOUT_CRC_EN
  typedef enum logic [2:0] {StIdle, StHdr, StFetch, StWait, StSend, StTrl, StCrc} state_e;
`else
  typedef enum logic [2:0] {StIdle, StHdr, StFetch, StWait, StSend, StTrl} state_e;
`endif

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] start_q, start_d;
  logic [CNT_W-1:0]     n_q, n_d;
  logic [CNT_W-1:0]     word_idx_q, word_idx_d;
  logic [7:0]           byte_idx_q, byte_idx_d;
  logic [WORD_W-1:0]    word_q, word_d;
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic                 valid;
  logic [7:0]           data;
  logic                 rd_ena;
  logic [15:0]          n16;

`ifdef ICETAP_READOUT_CRC_EN
  logic [7:0] crc_q, crc_d;

  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] din);
    logic [7:0] c;
    c = crc ^ din;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction
`endif

  assign n16 = 16'(n_q);

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    rd_addr_d  = rd_addr_q;
    valid      = 1'b0;
    data       = 8'h00;
    rd_ena     = 1'b0;
`ifdef ICETAP_READOUT_CRC_EN
    crc_d      = crc_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.dump_req) begin
          start_d    = bus.start_addr;
          // Modular distance plus one: start==stop is 1, stop==start-1 is the full depth.
          n_d        = {1'b0, bus.stop_addr - bus.start_addr} + CNT_W'(1);
          word_idx_d = '0;
          byte_idx_d = '0;
`ifdef ICETAP_READOUT_CRC_EN
          crc_d      = '0;
`endif
          state_d    = StHdr;
        end
      end
      StHdr: begin
        valid = 1'b1;
        if (byte_idx_q == 8'd0)      data = 8'hA5;
        else if (byte_idx_q == 8'd1) data = n16[7:0];
        else                         data = n16[15:8];
        if (bus.tx_ready) begin
          if (byte_idx_q == 8'd2) begin
            byte_idx_d = '0;
            rd_addr_d  = start_q;
            state_d    = StFetch;
          end else begin
            byte_idx_d = byte_idx_q + 8'd1;
          end
        end
      end
      StFetch: begin
        rd_ena  = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        word_d  = WORD_W'(bus.rd_data);
        state_d = StSend;
      end
      StSend: begin
        // Word register shifts right per transfer, so the low byte is always next.
        valid = 1'b1;
        data  = word_q[7:0];
        if (bus.tx_ready) begin
          word_d = word_q >> 8;
          if (byte_idx_q == LastByte) begin
            byte_idx_d = '0;
            if (word_idx_q == n_q - CNT_W'(1)) begin
`ifdef ICETAP_READOUT_CRC_EN
              state_d = StCrc;
`else
              state_d = StTrl;
`endif
            end else begin
              word_idx_d = word_idx_q + CNT_W'(1);
              rd_addr_d  = start_q + word_idx_d[ADDR_BITS-1:0];
              state_d    = StFetch;
            end
          end else begin
            byte_idx_d = byte_idx_q + 8'd1;
          end
        end
      end
`ifdef ICETAP_READOUT_CRC_EN
      StCrc: begin
        valid = 1'b1;
        data  = crc_q;
        if (bus.tx_ready) state_d = StTrl;
      end
`endif
      StTrl: begin
        valid = 1'b1;
        data  = 8'h5A;
        if (bus.tx_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
`ifdef ICETAP_READOUT_CRC_EN
    if (valid && bus.tx_ready && (state_q == StHdr || state_q == StSend)) begin
      crc_d = crc8_next(crc_q, data);
    end
`endif
  end

  always_ff @(posedge scan_clk) begin
    if (scan_reset) begin
      state_q    <= StIdle;
      start_q    <= '0;
      n_q        <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      rd_addr_q  <= '0;
`ifdef ICETAP_READOUT_CRC_EN
      crc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      rd_addr_q  <= rd_addr_d;
`ifdef ICETAP_READOUT_CRC_EN
      crc_q      <= crc_d;
`endif
    end
  end

  assign bus.tx_valid = valid;
  assign bus.tx_data  = data;
  assign bus.rd_ena   = rd_ena;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.busy     = (state_q != StIdle);
endmodule

// File: tb/tb_icetap_readout.sv
// Scoreboard bench for icetap_readout: 16-bit/256-deep instance plus a 12-bit instance.
module tb_icetap_readout;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

`ifdef ICETAP_READOUT_CRC_EN
  localparam int CrcExtra = 1;
`else
  localparam int CrcExtra = 0;
`endif

  icetap_readout_if #(.NR_SIGNALS(16), .RECORD_DEPTH(256)) bus_a ();
  icetap_readout_if #(.NR_SIGNALS(12), .RECORD_DEPTH(256)) bus_b ();

  icetap_readout #(.NR_SIGNALS(16), .RECORD_DEPTH(256)) u_dut_a (
    .scan_clk   (clk),
    .scan_reset (rst),
    .bus        (bus_a)
  );

  icetap_readout #(.NR_SIGNALS(12), .RECORD_DEPTH(256)) u_dut_b (
    .scan_clk   (clk),
    .scan_reset (rst),
    .bus        (bus_b)
  );

  // RAM models: one-cycle read latency
  always @(posedge clk) if (bus_a.rd_ena) bus_a.rd_data <= {bus_a.rd_addr, ~bus_a.rd_addr};
  always @(posedge clk) if (bus_b.rd_ena) bus_b.rd_data <= 12'hABC;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic [7:0] addr_a[$];
  logic [7:0] addr_b[$];
  bit bp = 1'b0;
  logic pv_a = 1'b0;
  logic pr_a = 1'b0;
  logic [7:0] pd_a = 8'h00;
  logic [7:0] basic_bytes [11] = '{8'hA5, 8'h04, 8'h00, 8'hEF, 8'h10, 8'hEE, 8'h11, 8'hED,
                                   8'h12, 8'hEC, 8'h13};
`ifdef ICETAP_READOUT_CRC_EN
  logic [7:0] crc_run = 8'h00;

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] x;
    x = c ^ d;
    for (int i = 0; i < 8; i++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    return x;
  endfunction
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input bit to_b, input logic [7:0] b);
    if (to_b) exp_b.push_back(b);
    else exp_a.push_back(b);
`ifdef ICETAP_READOUT_CRC_EN
    crc_run = crc8(crc_run, b);
`endif
  endtask

  task automatic close_frame(input bit to_b);
`ifdef ICETAP_READOUT_CRC_EN
    if (to_b) exp_b.push_back(crc_run);
    else exp_a.push_back(crc_run);
`endif
    if (to_b) exp_b.push_back(8'h5A);
    else exp_a.push_back(8'h5A);
  endtask

  task automatic gen_a(input logic [7:0] s, input logic [7:0] e);
    logic [8:0] n;
    logic [7:0] a;
`ifdef ICETAP_READOUT_CRC_EN
    crc_run = 8'h00;
`endif
    n = {1'b0, e - s} + 9'd1;
    push(1'b0, 8'hA5);
    push(1'b0, n[7:0]);
    push(1'b0, {7'd0, n[8]});
    for (int i = 0; i < int'(n); i++) begin
      a = s + 8'(i);
      addr_a.push_back(a);
      push(1'b0, ~a);
      push(1'b0, a);
    end
    close_frame(1'b0);
  endtask

  task automatic run_a(input logic [7:0] s, input logic [7:0] e, input int exp_busy,
                       input bit poke);
    int cnt;
    int guard;
    @(posedge clk); #1;
    bus_a.start_addr = s;
    bus_a.stop_addr  = e;
    bus_a.dump_req   = 1'b1;
    @(posedge clk); #1;
    bus_a.dump_req = 1'b0;
    cnt = 0;
    guard = 0;
    while (bus_a.busy && guard < 20000) begin
      @(negedge clk);
      if (bus_a.busy) cnt++;
      guard++;
      if (poke && cnt == 5) begin
        bus_a.dump_req   = 1'b1;
        bus_a.start_addr = 8'h80;
        bus_a.stop_addr  = 8'h90;
      end else begin
        bus_a.dump_req = 1'b0;
      end
    end
    bus_a.dump_req = 1'b0;
    if (guard >= 20000) begin
      checks++;
      failures++;
      $display("FAIL dump_timeout: busy still %0b after %0d cycles, required 0", bus_a.busy, guard);
    end
    if (exp_busy >= 0) check("busy_cycles", cnt, exp_busy);
  endtask

  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv_a = 1'b0;
      end else begin
        if (pv_a && !pr_a) begin
          check("hold_valid", bus_a.tx_valid, 1);
          check("hold_data", bus_a.tx_data, pd_a);
        end
        if (bus_a.tx_valid && bus_a.tx_ready) begin
          if (exp_a.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_byte_a: got %0h expected no byte", bus_a.tx_data);
          end else begin
            e = exp_a.pop_front();
            check("byte_a", bus_a.tx_data, e);
          end
        end
        if (bus_a.rd_ena) begin
          if (addr_a.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_read_a: got addr %0h expected no read", bus_a.rd_addr);
          end else begin
            e = addr_a.pop_front();
            check("rd_addr_a", bus_a.rd_addr, e);
          end
        end
        pv_a = bus_a.tx_valid;
        pr_a = bus_a.tx_ready;
        pd_a = bus_a.tx_data;
        if (bus_b.tx_valid && bus_b.tx_ready) begin
          if (exp_b.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_byte_b: got %0h expected no byte", bus_b.tx_data);
          end else begin
            e = exp_b.pop_front();
            check("byte_b", bus_b.tx_data, e);
          end
        end
        if (bus_b.rd_ena) begin
          if (addr_b.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_read_b: got addr %0h expected no read", bus_b.rd_addr);
          end else begin
            e = addr_b.pop_front();
            check("rd_addr_b", bus_b.rd_addr, e);
          end
        end
      end
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clk); #1;
      bus_a.tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  initial begin
    int guard;
    bus_a.dump_req = 1'b0; bus_a.start_addr = '0; bus_a.stop_addr = '0; bus_a.tx_ready = 1'b1;
    bus_b.dump_req = 1'b0; bus_b.start_addr = '0; bus_b.stop_addr = '0; bus_b.tx_ready = 1'b1;
    fork
      monitor();
      ready_drv();
    join_none

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus_a.busy, 0);
    check("rst_tx_valid", bus_a.tx_valid, 0);
    check("rst_tx_data", bus_a.tx_data, 0);
    check("rst_rd_ena", bus_a.rd_ena, 0);
    check("rst_rd_addr", bus_a.rd_addr, 0);
    check("rst_tx_valid_b", bus_b.tx_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic dump, hand-computed frame
`ifdef ICETAP_READOUT_CRC_EN
    crc_run = 8'h00;
`endif
    foreach (basic_bytes[i]) push(1'b0, basic_bytes[i]);
    close_frame(1'b0);
    for (int i = 0; i < 4; i++) addr_a.push_back(8'h10 + 8'(i));
    run_a(8'h10, 8'h13, 20 + CrcExtra, 1'b0);

    // Wrap-around: reads FE FF 00 01
    gen_a(8'hFE, 8'h01);
    run_a(8'hFE, 8'h01, 3 + 4 * 4 + 1 + CrcExtra, 1'b0);

    // Full buffer: N=256, header A5 00 01
    gen_a(8'h40, 8'h3F);
    run_a(8'h40, 8'h3F, 3 + 256 * 4 + 1 + CrcExtra, 1'b0);

    // Backpressure
    bp = 1'b1;
    gen_a(8'h30, 8'h37);
    run_a(8'h30, 8'h37, -1, 1'b0);
    bp = 1'b0;

    // dump_req mid-dump is ignored
    gen_a(8'h20, 8'h22);
    run_a(8'h20, 8'h22, 3 + 3 * 4 + 1 + CrcExtra, 1'b1);

    // Abort with reset during SEND
    @(posedge clk); #1;
    bus_a.start_addr = 8'h50; bus_a.stop_addr = 8'h53; bus_a.dump_req = 1'b1;
    addr_a.push_back(8'h50);
    for (int i = 0; i < 3; i++) exp_a.push_back(basic_bytes[0]);
    exp_a[1] = 8'h04;
    exp_a[2] = 8'h00;
    @(posedge clk); #1;
    bus_a.dump_req = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!bus_a.rd_ena && guard < 100);
    check("abort_fetch_seen", bus_a.rd_ena, 1);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_a.delete();
    addr_a.delete();
    @(negedge clk);
    check("abort_tx_valid", bus_a.tx_valid, 0);
    check("abort_busy", bus_a.busy, 0);
    check("abort_rd_ena", bus_a.rd_ena, 0);

    // Fresh dump after abort
    gen_a(8'h07, 8'h08);
    run_a(8'h07, 8'h08, 3 + 2 * 4 + 1 + CrcExtra, 1'b0);

    // 12-bit instance: A5 01 00 BC 0A [crc] 5A
`ifdef ICETAP_READOUT_CRC_EN
    crc_run = 8'h00;
`endif
    push(1'b1, 8'hA5); push(1'b1, 8'h01); push(1'b1, 8'h00); push(1'b1, 8'hBC); push(1'b1, 8'h0A);
    close_frame(1'b1);
    addr_b.push_back(8'h05);
    @(posedge clk); #1;
    bus_b.start_addr = 8'h05; bus_b.stop_addr = 8'h05; bus_b.dump_req = 1'b1;
    @(posedge clk); #1;
    bus_b.dump_req = 1'b0;
    guard = 0;
    while (bus_b.busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("b_done", bus_b.busy, 0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("exp_a_drained", exp_a.size(), 0);
    check("exp_b_drained", exp_b.size(), 0);
    check("addr_a_drained", addr_a.size(), 0);
    check("addr_b_drained", addr_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
